// File: rtl/serial_sub4.sv
// serial_sub4: bit-serial subtractor, LSB first, one full-subtractor cell
// iterated over WIDTH cycles with a start/done handshake.
// Optional feature: define SUB_OVERFLOW_EN to add the oOVF signed-overflow output.
module serial_sub4 #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iSTART,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic [WIDTH-1:0] oDIFF,
    output logic             oBORROW,
    output logic             oBUSY,
`ifdef SUB_OVERFLOW_EN
    output logic             oOVF,
`endif
    output logic             oDONE
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               done_q, done_d;
`ifdef SUB_OVERFLOW_EN
    logic               ovf_q, ovf_d;
`endif

    // Full-subtractor cell operating on the current LSBs of the operand shift registers.
    logic bit_a, bit_b, bit_d, bit_bout;

    always_comb begin
        bit_a    = a_q[0];
        bit_b    = b_q[0];
        bit_d    = bit_a ^ bit_b ^ bin_q;
        bit_bout = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bin_q);
    end

    // Next-state and datapath updates; outputs only change on completion.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
`ifdef SUB_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (iSTART) begin
                    a_d     = iA;
                    b_d     = iB;
                    res_d   = '0;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d = {bit_d, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bin_d = bit_bout;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LastCnt) begin
                    // After WIDTH-1 shifts the operand LSBs hold the original MSBs.
                    diff_d   = {bit_d, res_q[WIDTH-1:1]};
                    borrow_d = bit_bout;
`ifdef SUB_OVERFLOW_EN
                    ovf_d    = (bit_a ^ bit_b) & (bit_a ^ bit_d);
`endif
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign oDIFF   = diff_q;
    assign oBORROW = borrow_q;
    assign oDONE   = done_q;
    assign oBUSY   = (state_q == StRun);
`ifdef SUB_OVERFLOW_EN
    assign oOVF    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub4.sv
// Directed testbench for serial_sub4 (default width 4).
module tb_serial_sub4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] diff;
    logic       borrow;
    logic       busy;
    logic       done;
`ifdef SUB_OVERFLOW_EN
    logic       ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_sub4 #(
        .WIDTH(4),
        .CNT_W(3)
    ) dut (
        .iCLK   (clk),
        .iRST   (rst),
        .iSTART (start),
        .iA     (a),
        .iB     (b),
        .oDIFF  (diff),
        .oBORROW(borrow),
        .oBUSY  (busy),
`ifdef SUB_OVERFLOW_EN
        .oOVF   (ovf),
`endif
        .oDONE  (done)
    );

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for oDONE; reports latency and busy cycles.
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                          output int lat, output int busy_cnt);
        a     = av;
        b     = bv;
        start = 1'b1;
        step();
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        step();
        step();
        rst = 1'b0;
        n_tests++;
        if (diff !== 4'd0 || borrow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got diff=%0d borrow=%b busy=%b done=%b, expected 0 0 0 0",
                     diff, borrow, busy, done);
        end
`ifdef SUB_OVERFLOW_EN
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b expected 0", ovf);
        end
`endif
    endtask

    task automatic test_basic();
        int lat, bc;
        run_op(4'd7, 4'd3, lat, bc);
        n_tests++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 4", lat);
        end
        n_tests++;
        if (bc !== 4) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d expected 4", bc);
        end
        n_tests++;
        if (diff !== 4'd4 || borrow !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got diff=%0d borrow=%b busy=%b expected 4 0 0",
                     diff, borrow, busy);
        end
        step();
        n_tests++;
        if (done !== 1'b0 || diff !== 4'd4 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got done=%b diff=%0d busy=%b expected 0 4 0",
                     done, diff, busy);
        end
    endtask

    task automatic test_vectors();
        logic [3:0] va [4] = '{4'd3, 4'd15, 4'd0, 4'd0};
        logic [3:0] vb [4] = '{4'd7, 4'd15, 4'd0, 4'd1};
        logic [3:0] vd [4] = '{4'd12, 4'd0, 4'd0, 4'd15};
        logic       vw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], lat, bc);
            n_tests++;
            if (lat !== 4 || diff !== vd[i] || borrow !== vw[i]) begin
                n_fail++;
                $display("FAIL vector_%0d (%0d-%0d): got lat=%0d diff=%0d borrow=%b expected 4 %0d %b",
                         i, va[i], vb[i], lat, diff, borrow, vd[i], vw[i]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int         n_done = 0;
        int         first_done = -1;
        logic [3:0] d_first = 4'hx;
        logic [3:0] d_second = 4'hx;
        logic       busy_c5 = 1'bx;
        int         guard = 0;
        a     = 4'd9;
        b     = 4'd2;
        start = 1'b1;
        step();
        a = 4'd1;
        b = 4'd1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 5) busy_c5 = busy;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    first_done = c;
                    d_first    = diff;
                end else if (n_done == 2) begin
                    d_second = diff;
                end
            end
        end
        start = 1'b0;
        n_tests++;
        if (first_done !== 4 || d_first !== 4'd7) begin
            n_fail++;
            $display("FAIL b2b_first: got cycle=%0d diff=%0d expected 4 7", first_done, d_first);
        end
        n_tests++;
        if (busy_c5 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: got busy=%b expected 0", busy_c5);
        end
        n_tests++;
        if (n_done !== 2 || d_second !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_second: got dones=%0d diff=%0d expected 2 0", n_done, d_second);
        end
        // Drain the third operation accepted at the end of the window.
        while ((busy || done) && guard < 20) begin
            step();
            guard++;
        end
        step();
    endtask

    task automatic test_abort();
        int lat, bc;
        int spurious = 0;
        run_op(4'd7, 4'd8, lat, bc);
        step();
        n_tests++;
        if (diff !== 4'd15 || borrow !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_setup: got diff=%0d borrow=%b expected 15 1", diff, borrow);
        end
        a     = 4'd5;
        b     = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (diff !== 4'd0 || borrow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_clear: got diff=%0d borrow=%b busy=%b done=%b expected 0 0 0 0",
                     diff, borrow, busy, done);
        end
`ifdef SUB_OVERFLOW_EN
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ovf: got %b expected 0", ovf);
        end
`endif
        for (int c = 0; c < 8; c++) begin
            step();
            if (done || busy) spurious++;
        end
        n_tests++;
        if (spurious !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", spurious);
        end
        // Reset and start together: request must be dropped.
        a     = 4'd9;
        b     = 4'd4;
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        step();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_start_collide: got busy=%b done=%b diff=%0d expected 0 0 0",
                     busy, done, diff);
        end
        run_op(4'd6, 4'd6, lat, bc);
        n_tests++;
        if (lat !== 4 || diff !== 4'd0 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_recover: got lat=%0d diff=%0d borrow=%b expected 4 0 0",
                     lat, diff, borrow);
        end
        step();
    endtask

`ifdef SUB_OVERFLOW_EN
    task automatic test_overflow();
        logic [3:0] va [3] = '{4'd7, 4'd8, 4'd5};
        logic [3:0] vb [3] = '{4'd8, 4'd1, 4'd3};
        logic [3:0] vd [3] = '{4'd15, 4'd7, 4'd2};
        logic       vo [3] = '{1'b1, 1'b1, 1'b0};
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], lat, bc);
            n_tests++;
            if (lat !== 4 || diff !== vd[i] || ovf !== vo[i]) begin
                n_fail++;
                $display("FAIL ovf_%0d (%0d-%0d): got lat=%0d diff=%0d ovf=%b expected 4 %0d %b",
                         i, va[i], vb[i], lat, diff, ovf, vd[i], vo[i]);
            end
            step();
        end
    endtask
`endif

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        test_reset();
        test_basic();
        test_vectors();
        test_back_to_back();
        test_abort();
`ifdef SUB_OVERFLOW_EN
        test_overflow();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
